// File: rtl/rr_arbiter_beats.sv
// Round-robin N:1 beat arbiter with packet locking on last_in and a registered,
// full-throughput output stage that carries data, last and the source index.
module rr_arbiter_beats #(
    parameter int DATA_WD = 8,
    parameter int N       = 4,
    parameter int ID_WD   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         valid_in,
    input  logic [N*DATA_WD-1:0] data_in,
    input  logic [N-1:0]         last_in,
    output logic [N-1:0]         ready_in,
    output logic                 valid_out,
    output logic [DATA_WD-1:0]   data_out,
    output logic                 last_out,
    output logic [ID_WD-1:0]     id_out,
    input  logic                 ready_out
);

    // Handshake: a beat moves on any rising edge where valid and ready are both
    // high on the same port. The output stage accepts a new beat whenever it is
    // empty or its current beat leaves in the same cycle.

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e          state_q, state_d;
    logic [ID_WD-1:0]     ptr_q, ptr_d;
    logic [ID_WD-1:0]     owner_q, owner_d;
    logic                 valid_q, valid_d;
    logic [DATA_WD-1:0]   data_q, data_d;
    logic                 last_q, last_d;
    logic [ID_WD-1:0]     id_q, id_d;

    logic                 slot_free;
    logic                 sel_found;
    logic [ID_WD-1:0]     sel;
    logic                 in_fire;
    logic [DATA_WD-1:0]   sel_data;
    logic                 sel_last;

    // State register: lock FSM, priority pointer and the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OPEN;
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    // Output logic: grant selection and the per-requester ready vector.
    always_comb begin : output_comb
        sel_found = 1'b0;
        sel       = '0;
        if (state_q == ST_LOCKED) begin
            sel_found = 1'b1;
            sel       = owner_q;
        end else begin
            // Two passes give the rotating scan ptr..N-1 then 0..ptr-1.
            for (int i = 0; i < N; i++) begin
                if (!sel_found && valid_in[i] && (ID_WD'(i) >= ptr_q)) begin
                    sel_found = 1'b1;
                    sel       = ID_WD'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!sel_found && valid_in[i] && (ID_WD'(i) < ptr_q)) begin
                    sel_found = 1'b1;
                    sel       = ID_WD'(i);
                end
            end
        end

        slot_free = !valid_q || ready_out;

        ready_in = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            ready_in[i] = rst_n && slot_free && sel_found && (ID_WD'(i) == sel);
            if (ID_WD'(i) == sel) begin
                sel_data = data_in[i*DATA_WD +: DATA_WD];
                sel_last = last_in[i];
            end
        end

        in_fire = |(valid_in & ready_in);
    end

    // Next-state logic: load on input fire, otherwise drain on output fire.
    always_comb begin : next_state_comb
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        id_d    = id_q;

        if (in_fire) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            last_d  = sel_last;
            id_d    = sel;
            if (sel_last) begin
                state_d = ST_OPEN;
                ptr_d   = (sel == ID_WD'(N - 1)) ? '0 : sel + ID_WD'(1);
            end else begin
                state_d = ST_LOCKED;
                owner_d = sel;
            end
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;
    assign id_out    = id_q;

endmodule

// File: tb/tb_rr_arbiter_beats.sv
// Bench for rr_arbiter_beats: directed scenarios followed by randomized traffic,
// all checked against a packet-level arbitration model and per-source queues.
module tb_rr_arbiter_beats;

    localparam int DATA_WD = 8;
    localparam int N       = 4;
    localparam int ID_WD   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         valid_in;
    logic [N*DATA_WD-1:0] data_in;
    logic [N-1:0]         last_in;
    logic [N-1:0]         ready_in;
    logic                 valid_out;
    logic [DATA_WD-1:0]   data_out;
    logic                 last_out;
    logic [ID_WD-1:0]     id_out;
    logic                 ready_out;

    rr_arbiter_beats #(.DATA_WD(DATA_WD), .N(N), .ID_WD(ID_WD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .id_out    (id_out),
        .ready_out (ready_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stimulus sources and scoreboard ----------------
    logic [8:0]         src_q [N][$];   // {last, data} beats waiting per requester
    logic [DATA_WD-1:0] exp_q [N][$];   // accepted beats not yet delivered
    logic [N-1:0]       en;
    logic [N-1:0]       rdy_seen;

    int checks   = 0;
    int failures = 0;

    // packet-level model of the arbiter
    int                 m_ptr;
    bit                 m_locked;
    int                 m_owner;
    bit                 m_vout;
    logic [DATA_WD-1:0] m_data;
    logic               m_last;
    int                 m_id;

    bit   have_prev;
    logic prev_last;
    int   prev_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int i, input logic [7:0] d, input logic l);
        src_q[i].push_back({l, d});
    endtask

    task automatic drive_inputs();
        logic [8:0] head;
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                head = src_q[i][0];
                valid_in[i] = 1'b1;
                last_in[i]  = head[8];
                data_in[i*DATA_WD +: DATA_WD] = head[7:0];
            end else begin
                valid_in[i] = 1'b0;
                last_in[i]  = 1'($urandom_range(0, 1));
                data_in[i*DATA_WD +: DATA_WD] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_vout    = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        m_id      = 0;
        have_prev = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    // One clock cycle: drive at the falling edge, check grants, advance the model,
    // then check the registered outputs at the next falling edge.
    task automatic run_cycle();
        logic [N-1:0] exp_rdy;
        logic [8:0]   beat;
        bit           has;
        bit           slot_free;
        bit           fire;
        int           sel;
        int           idx;
        int           oid;

        drive_inputs();
        #1;
        rdy_seen  = ready_in;
        slot_free = !m_vout || ready_out;
        has = 1'b0;
        sel = 0;
        if (m_locked) begin
            has = 1'b1;
            sel = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!has && valid_in[idx]) begin
                    has = 1'b1;
                    sel = idx;
                end
            end
        end
        exp_rdy = '0;
        if (has && slot_free) exp_rdy[sel] = 1'b1;
        check("ready_in", 32'(ready_in), 32'(exp_rdy));

        if (m_vout && ready_out) begin
            oid = int'(id_out);
            check("sb_pending", 32'(exp_q[oid].size() != 0), 32'd1);
            if (exp_q[oid].size() != 0) check("sb_data", 32'(data_out), 32'(exp_q[oid].pop_front()));
            if (have_prev && !prev_last) check("sb_contig", 32'(id_out), 32'(prev_id));
            have_prev = 1'b1;
            prev_last = last_out;
            prev_id   = oid;
        end

        fire = has && slot_free && valid_in[sel];
        if (fire) begin
            beat = src_q[sel].pop_front();
            exp_q[sel].push_back(beat[7:0]);
            m_vout = 1'b1;
            m_data = beat[7:0];
            m_last = beat[8];
            m_id   = sel;
            if (beat[8]) begin
                m_locked = 1'b0;
                m_ptr    = (sel + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = sel;
            end
        end else if (m_vout && ready_out) begin
            m_vout = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        check("valid_out", 32'(valid_out), 32'(m_vout));
        check("data_out", 32'(data_out), 32'(m_data));
        check("last_out", 32'(last_out), 32'(m_last));
        check("id_out", 32'(id_out), 32'(m_id));
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_in", 32'(ready_in), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_last_out", 32'(last_out), 32'd0);
        check("rst_id_out", 32'(id_out), 32'd0);
    endtask

    task automatic apply_reset(input int hold_cycles, input bit clear_src);
        rst_n = 1'b0;
        drive_inputs();
        #1;
        check_reset_outputs();
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        if (clear_src) for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- directed steps, then random traffic ----------------
    initial begin
        logic [7:0] lock_d [4];
        int         lock_id [4];
        int         plen;

        valid_in  = '0;
        data_in   = '0;
        last_in   = '0;
        ready_out = 1'b1;
        en        = '1;
        rst_n     = 1'b0;

        // Reset with every requester valid, then round-robin fairness.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push_beat(i, 8'(16 * i + r), 1'b1);
        apply_reset(3, 1'b0);
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            check("fair_id", 32'(id_out), 32'(k % N));
            check("fair_valid", 32'(valid_out), 32'd1);
        end

        // Packet lock: req1 three beats while req2 waits.
        lock_d[0] = 8'h11; lock_d[1] = 8'h12; lock_d[2] = 8'h13; lock_d[3] = 8'h21;
        lock_id[0] = 1; lock_id[1] = 1; lock_id[2] = 1; lock_id[3] = 2;
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h12, 1'b0);
        push_beat(1, 8'h13, 1'b1);
        push_beat(2, 8'h21, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            check("lock_data", 32'(data_out), 32'(lock_d[k]));
            check("lock_id", 32'(id_out), 32'(lock_id[k]));
        end

        // Lock gap: req0 goes idle mid-packet while req3 keeps requesting.
        push_beat(0, 8'h31, 1'b0);
        push_beat(0, 8'h32, 1'b0);
        push_beat(0, 8'h33, 1'b1);
        push_beat(3, 8'h3F, 1'b1);
        en = 4'b0001;
        run_cycle();
        check("gap_first_id", 32'(id_out), 32'd0);
        en = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            check("gap_rdy3", 32'(rdy_seen[3]), 32'd0);
        end
        en = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            check("gap_rdy3_tail", 32'(rdy_seen[3]), 32'd0);
        end
        run_cycle();
        check("gap_switch_rdy", 32'(rdy_seen), 32'b1000);
        check("gap_switch_data", 32'(data_out), 32'h3F);
        en = '1;

        // Backpressure: 0xA5 held for four cycles, then next beat with no bubble.
        push_beat(2, 8'hA5, 1'b1);
        push_beat(2, 8'hB6, 1'b1);
        ready_out = 1'b1;
        run_cycle();
        check("bp_load", 32'(data_out), 32'hA5);
        ready_out = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            check("bp_hold_data", 32'(data_out), 32'hA5);
            check("bp_hold_rdy", 32'(rdy_seen), 32'd0);
        end
        ready_out = 1'b1;
        run_cycle();
        check("bp_release_rdy", 32'(rdy_seen), 32'b0100);
        check("bp_release_data", 32'(data_out), 32'hB6);

        // Wrap: pointer sits at 3, so req3 goes before req0.
        push_beat(3, 8'hC3, 1'b1);
        push_beat(0, 8'hC0, 1'b1);
        run_cycle();
        check("wrap_id_first", 32'(id_out), 32'd3);
        run_cycle();
        check("wrap_id_second", 32'(id_out), 32'd0);

        // Reset while req0 holds the lock; req1 must win afterwards.
        push_beat(0, 8'hD0, 1'b0);
        push_beat(0, 8'hD1, 1'b1);
        en = 4'b0001;
        run_cycle();
        check("mid_lock_last", 32'(last_out), 32'd0);
        apply_reset(2, 1'b1);
        en = 4'b0010;
        push_beat(1, 8'hE1, 1'b1);
        run_cycle();
        check("post_rst_rdy", 32'(rdy_seen), 32'b0010);
        check("post_rst_id", 32'(id_out), 32'd1);
        en = '1;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 9) < 8);
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    plen = int'($urandom_range(1, 4));
                    for (int b = 0; b < plen; b++)
                        push_beat(i, 8'($urandom_range(0, 255)), (b == plen - 1));
                end
            end
            ready_out = ($urandom_range(0, 3) != 0);
            if (c == 1500) apply_reset(2, 1'b1);
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_beats.md
# rr_arbiter_beats

Round-robin arbiter that merges N valid/ready beat streams into one output valid/ready stream, with packet locking on `last`. It sits in front of a shared downstream beat consumer, such as a register slice or a single-port sink, and decides which requester owns it. The output is a full-throughput registered forward stage. Output data, `last` and source ID change only on a clock edge.

## Interface
Parameters:
- `DATA_WD`, default 8: beat data width.
- `N`, default 4: number of requesters, N ≥ 2.
- `ID_WD`, default `$clog2(N)`: width of the source ID.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  N  per-requester beat valid.
- `data_in`  in  N*DATA_WD  requester i occupies bits [i*DATA_WD +: DATA_WD].
- `last_in`  in  N  per-requester end-of-packet flag.
- `ready_in`  out  N  per-requester ready; at most one bit high per cycle.
- `valid_out`  out  1  registered output valid.
- `data_out`  out  DATA_WD  registered output data.
- `last_out`  out  1  registered output last.
- `id_out`  out  ID_WD  registered index of the source requester of the current output beat.
- `ready_out`  in  1  downstream ready.

## Operation
- Beat transfer definitions:
  - Input fire on i: `valid_in[i] && ready_in[i]`.
  - Output fire: `valid_out && ready_out`.
- State registers:
  - `ptr` [ID_WD]: highest-priority requester.
  - `locked` (1 bit).
  - `owner` [ID_WD].
- `slot_free = !valid_out || ready_out`.
- Selection `sel`, combinational:
  - If `locked`: `sel = owner`.
  - Else: `sel` = first i with `valid_in[i]`, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - If none is valid, no selection.
- `ready_in[i] = slot_free && (i == sel)`, with a selection existing if unlocked. All other bits are 0.
  - In the unlocked state `ready_in` depends combinationally on `valid_in`; this is permitted.
- On an input fire from `sel`:
  - `data_out`, `last_out`, `id_out` load the beat; `valid_out` is set to 1.
  - If `last_in[sel]` = 0: `locked` ← 1, `owner` ← sel.
  - If `last_in[sel]` = 1: `locked` ← 0, `ptr` ← sel+1, wrapping N-1 → 0.
- With no input fire and an output fire: `valid_out` ← 0. Data, `last_out` and `id_out` hold their values.
- While locked:
  - The owner may drop `valid_in` between beats. The lock holds and no other requester is granted, however long the gap.
- Packet of a single beat (`last_in` = 1 on its first beat): no lock; the pointer advances immediately.
- `ptr` changes only on accepted last beats. A requester that never wins keeps its priority position.

## Timing
- Reset (async assert, sync-safe deassert by integration):
  - `valid_out` = 0, `data_out` = 0, `last_out` = 0, `id_out` = 0.
  - `ptr` = 0, `locked` = 0.
  - `ready_in` is forced to all-zero while `rst_n` = 0.
- Reset asserted mid-packet: the lock is dropped and any held output beat is lost. After reset, arbitration restarts from requester 0.
- Latency: input fire at edge k puts the beat on the outputs after edge k; `valid_out` is visible in cycle k+1.
- Throughput: one beat per cycle sustained while `ready_out` = 1.
- Backpressure: while `valid_out && !ready_out`:
  - `ready_in` is all-zero.
  - `data_out`, `last_out` and `id_out` are stable.
- Simultaneous output fire and input fire in the same cycle: the new beat replaces the old one and `valid_out` stays 1.
- Arbitration switch: after the last beat of requester A is accepted in cycle k, a different requester can be granted in cycle k+1. There are no idle cycles between packets.

## Test plan
- Reset: hold `rst_n` = 0 with all `valid_in` = 1 → `ready_in` = 0, `valid_out` = 0, all outputs 0. Release → requester 0 is granted first, `id_out` = 0 one cycle later.
- Fairness: N = 4, all requesters continuously valid, every beat `last` = 1, `ready_out` = 1 → `id_out` sequence 0,1,2,3,0,1,… with one beat per cycle.
- Packet lock: req1 sends a 3-beat packet (data 0x11, 0x12, 0x13; last on 0x13) while req2 is valid throughout → output is 0x11, 0x12, 0x13 with `id_out` = 1, then req2's beat next with `id_out` = 2.
- Lock gap: req0 drops valid for 5 cycles mid-packet while req3 is valid → `ready_in[3]` stays 0 until req0's last beat is accepted.
- Backpressure: `ready_out` = 0 for 4 cycles with output 0xA5 held → `data_out` = 0xA5 stable and `ready_in` = 0. Raise `ready_out` → the next beat is accepted in the same cycle with no bubble.
- Wrap and reset: ptr at 3, req3 single-beat then req0 valid → grant order 3 then 0. Assert `rst_n` while req0 is locked mid-packet → after release, `locked` = 0 and req1 can win if req0 is idle.
